// File: rtl/exp_sched_pkg.sv
// Shared constants and types for the exp-engine request scheduler and its result FIFO.
package exp_sched_pkg;
    localparam int EXP_DATA_W      = 32;
    localparam int EXP_INTB_W      = 4;
    localparam int EXP_LATENCY_DEF = 7;   // matches the engine's stage count
    localparam int TAG_W_MAX       = 3;   // enough for up to 8 requesters

    typedef struct packed {
        logic [TAG_W_MAX-1:0]  tag;
        logic [EXP_DATA_W-1:0] data;
    } res_entry_t;

    // Error causes, reserved for a later status register
    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_MISSING_TAG = 2'd1,
        ERR_LOST_RESULT = 2'd2,
        ERR_FIFO_OVF    = 2'd3
    } err_cause_t;

    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction
endpackage

// File: rtl/exp_result_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push into a
// full FIFO is dropped unless a pop frees a slot in the same cycle.
module exp_result_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    output logic             o_push_drop
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata     = r_mem[r_rd_ptr];
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_push_drop = i_push && !w_push;
endmodule

// File: rtl/exp_req_scheduler.sv
// Round-robin scheduler sharing one fixed-latency exp engine among NUM_REQ requesters.
// Optional perf counters are enabled with EXP_SCHED_PERF_CNT_EN.
module exp_req_scheduler
    import exp_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TAG_W       = 2,
    parameter int EXP_LATENCY = EXP_LATENCY_DEF,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [EXP_DATA_W*NUM_REQ-1:0] req_x,
    input  logic [EXP_INTB_W*NUM_REQ-1:0] req_int_bits,
    output logic [EXP_DATA_W-1:0]         exp_x_o,
    output logic [EXP_INTB_W-1:0]         exp_int_bits_o,
    output logic                          exp_valid_o,
    input  logic [EXP_DATA_W-1:0]         exp_result_i,
    input  logic                          exp_valid_i,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [EXP_DATA_W-1:0]         res_data,
    output logic [TAG_W-1:0]              res_tag,
    output logic [3:0]                    in_flight,
    output logic                          err_sticky
`ifdef EXP_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH);

    logic [TAG_W-1:0]                  r_rr_ptr;
    logic [EXP_DATA_W-1:0]             r_exp_x;
    logic [EXP_INTB_W-1:0]             r_exp_intb;
    logic                              r_exp_vld;
    logic [TAG_W-1:0]                  r_exp_tag;
    logic [EXP_LATENCY-1:0]            r_tl_vld;
    logic [EXP_LATENCY-1:0][TAG_W-1:0] r_tl_tag;
    logic [3:0]                        r_in_flight;
    logic                              r_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [TAG_W-1:0]   w_gnt_idx;
    logic               w_gnt_any, w_credit_ok, w_accept;
    logic               w_head_vld, w_push, w_pop, w_empty, w_push_drop;
    logic [TAG_W-1:0]   w_head_tag;
    logic [CW:0]        w_fifo_count;
    res_entry_t         w_wr_entry, w_rd_entry;

    // Credit covers both FIFO contents and ops still inside the engine, so a
    // non-stallable return always has a slot waiting for it.
    assign w_credit_ok = (int'(w_fifo_count) + int'(r_in_flight)) < FIFO_DEPTH;

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_any && req_valid[wrap_idx(int'(r_rr_ptr) + k, NUM_REQ)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = TAG_W'(wrap_idx(int'(r_rr_ptr) + k, NUM_REQ));
            end
        end
    end

    assign w_grant   = (w_gnt_any && w_credit_ok) ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_accept  = |(req_valid & w_grant);
    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_exp_x    <= '0;
            r_exp_intb <= '0;
            r_exp_vld  <= 1'b0;
            r_exp_tag  <= '0;
        end else begin
            r_exp_vld <= w_accept;
            if (w_accept) begin
                r_exp_x    <= req_x[EXP_DATA_W*int'(w_gnt_idx) +: EXP_DATA_W];
                r_exp_intb <= req_int_bits[EXP_INTB_W*int'(w_gnt_idx) +: EXP_INTB_W];
                r_exp_tag  <= w_gnt_idx;
                r_rr_ptr   <= TAG_W'(wrap_idx(int'(w_gnt_idx) + 1, NUM_REQ));
            end
        end
    end

    // Tag line is fed from the issue register, so its head lines up with exp_valid_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tl_vld <= '0;
            r_tl_tag <= '0;
        end else begin
            r_tl_vld[0] <= r_exp_vld;
            r_tl_tag[0] <= r_exp_tag;
            for (int s = 1; s < EXP_LATENCY; s++) begin
                r_tl_vld[s] <= r_tl_vld[s-1];
                r_tl_tag[s] <= r_tl_tag[s-1];
            end
        end
    end

    assign w_head_vld = r_tl_vld[EXP_LATENCY-1];
    assign w_head_tag = r_tl_tag[EXP_LATENCY-1];
    assign w_push     = exp_valid_i && w_head_vld;
    assign w_wr_entry = '{tag: TAG_W_MAX'(w_head_tag), data: exp_result_i};

    // An op leaves the credit pool when its tag leaves the line, even if the
    // engine lost the result, so a protocol error cannot leak credit forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_flight <= '0;
            r_err       <= 1'b0;
        end else begin
            r_in_flight <= r_in_flight + 4'(w_accept) - 4'(w_head_vld);
            if ((exp_valid_i != w_head_vld) || w_push_drop) r_err <= 1'b1;
        end
    end

    assign w_pop = !w_empty && res_ready;

    exp_result_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_push      (w_push),
        .i_wdata     (w_wr_entry),
        .i_pop       (w_pop),
        .o_rdata     (w_rd_entry),
        .o_empty     (w_empty),
        .o_count     (w_fifo_count),
        .o_push_drop (w_push_drop)
    );

    if (TAG_W < TAG_W_MAX) begin : g_tag_pad
        logic w_tag_unused;
        assign w_tag_unused = ^w_rd_entry.tag[TAG_W_MAX-1:TAG_W];
    end

    assign exp_x_o        = r_exp_x;
    assign exp_int_bits_o = r_exp_intb;
    assign exp_valid_o    = r_exp_vld;
    assign res_valid      = !w_empty;
    assign res_data       = w_rd_entry.data;
    assign res_tag        = w_rd_entry.tag[TAG_W-1:0];
    assign in_flight      = r_in_flight;
    assign err_sticky     = r_err;

`ifdef EXP_SCHED_PERF_CNT_EN
    logic [31:0] r_perf_issue, r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_issue <= r_perf_issue + 32'(w_accept);
            r_perf_stall <= r_perf_stall + 32'((|req_valid) && !w_credit_ok);
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_exp_req_scheduler.sv
// Directed bench for exp_req_scheduler with a latency-7 engine stub returning ~x.
module tb_exp_req_scheduler;
    localparam int NR  = 4;
    localparam int TW  = 2;
    localparam int LAT = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid, req_ready;
    logic [32*NR-1:0]  req_x;
    logic [4*NR-1:0]   req_int_bits;
    logic [31:0]       exp_x_o, exp_result_i, res_data;
    logic [3:0]        exp_int_bits_o, in_flight;
    logic              exp_valid_o, exp_valid_i, res_valid, res_ready, err_sticky;
    logic [TW-1:0]     res_tag;
`ifdef EXP_SCHED_PERF_CNT_EN
    logic [31:0]       perf_issue_cnt, perf_stall_cnt;
    logic [31:0]       pi0, ps0;
`endif

    always #5 clk = ~clk;

    exp_req_scheduler #(.NUM_REQ(NR), .TAG_W(TW), .EXP_LATENCY(LAT), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_int_bits(req_int_bits), .exp_x_o(exp_x_o),
        .exp_int_bits_o(exp_int_bits_o), .exp_valid_o(exp_valid_o),
        .exp_result_i(exp_result_i), .exp_valid_i(exp_valid_i),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .in_flight(in_flight), .err_sticky(err_sticky)
`ifdef EXP_SCHED_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Engine stub: never reset, so a scheduler reset leaves its results in flight
    logic [LAT-1:0] st_v = '0;
    logic [31:0]    st_d [LAT] = '{default: '0};
    always @(posedge clk) begin
        st_v    <= {st_v[LAT-2:0], exp_valid_o};
        st_d[0] <= ~exp_x_o;
        for (int s = 1; s < LAT; s++) st_d[s] <= st_d[s-1];
    end
    assign exp_valid_i  = st_v[LAT-1];
    assign exp_result_i = st_d[LAT-1];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted operand must come back once, in issue order, as {tag, ~x}
    logic [TW+31:0] sb_q [$];
    logic [TW+31:0] sb_e;
    always @(negedge clk) begin
        if (rst) begin
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_extra: got tag %0d data %h expected no result", res_tag, res_data);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_tag", 32'(res_tag), 32'(sb_e[TW+31:32]));
                    chk("sb_data", res_data, sb_e[31:0]);
                end
            end
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) sb_q.push_back({TW'(i), ~req_x[32*i +: 32]});
        end
    end

    task automatic set_x(input int seed);
        for (int i = 0; i < NR; i++) begin
            req_x[32*i +: 32]       = 32'hA000_0000 | (seed << 8) | i;
            req_int_bits[4*i +: 4]  = 4'(seed + i);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            step();
            @(negedge clk);
            n++;
        end while ((res_valid || in_flight != 0) && n < 60);
        chk({nm, "_idle"}, 32'(res_valid || in_flight != 0), 32'd0);
        chk({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({nm, "_err"}, 32'(err_sticky), 32'd0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_expv"}, 32'(exp_valid_o), 32'd0);
        chk({nm, "_expx"}, exp_x_o, 32'd0);
        chk({nm, "_expib"}, 32'(exp_int_bits_o), 32'd0);
        chk({nm, "_resv"}, 32'(res_valid), 32'd0);
        chk({nm, "_inflt"}, 32'(in_flight), 32'd0);
        chk({nm, "_err"}, 32'(err_sticky), 32'd0);
    endtask

    typedef struct {
        logic [NR-1:0] vld;
        logic [NR-1:0] rdy;
    } vec_t;
    vec_t tbl [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, acc;
        req_valid = '0; req_x = '0; req_int_bits = '0; res_ready = 1'b0;

        // Round-robin table, pointer starts at 3 after the single-op test grants requester 2
        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b1111, 4'b1000};
        tbl[2] = '{4'b1111, 4'b0001};
        tbl[3] = '{4'b1010, 4'b0010};
        tbl[4] = '{4'b1010, 4'b1000};
        tbl[5] = '{4'b0001, 4'b0001};
        tbl[6] = '{4'b0001, 4'b0001};
        tbl[7] = '{4'b0100, 4'b0100};
        tbl[8] = '{4'b0110, 4'b0010};

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst0");
        step();
        rst = 1'b1;
        res_ready = 1'b1;

        // Single op: requester 2, x=0x10
        step();
        req_x[95:64] = 32'h0000_0010;
        req_int_bits[11:8] = 4'h5;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("so_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("so_expv", 32'(exp_valid_o), 32'd1);
        chk("so_expx", exp_x_o, 32'h10);
        chk("so_expib", 32'(exp_int_bits_o), 32'h5);
        chk("so_inflt", 32'(in_flight), 32'd1);
        chk("so_resv_t1", 32'(res_valid), 32'd0);
        for (int k = 2; k <= 8; k++) begin
            step();
            @(negedge clk);
            chk("so_resv_early", 32'(res_valid), 32'd0);
        end
        step();
        @(negedge clk);
        chk("so_resv", 32'(res_valid), 32'd1);
        chk("so_data", res_data, 32'hFFFF_FFEF);
        chk("so_tag", 32'(res_tag), 32'd2);
        chk("so_inflt0", 32'(in_flight), 32'd0);
        step();
        @(negedge clk);
        chk("so_resv_after", 32'(res_valid), 32'd0);

        for (int r = 0; r < 9; r++) begin
            step();
            set_x(r);
            req_valid = tbl[r].vld;
            @(negedge clk);
            chk($sformatf("rr_row%0d", r), 32'(req_ready), 32'(tbl[r].rdy));
        end
        step();
        req_valid = '0;
        wait_idle("rr");

        // Fairness: all valid, credit-limited to 8 accepts per 10 cycles
        nxt = 2;
        acc = 0;
        for (int c = 0; c < 36; c++) begin
            step();
            set_x(16 + c);
            req_valid = '1;
            @(negedge clk);
            if (req_ready != '0) begin
                chk("fair_gnt", 32'(req_ready), 32'(1) << nxt);
                nxt = (nxt + 1) % NR;
                acc++;
            end
        end
        step();
        req_valid = '0;
        chk("fair_accepts", 32'(acc), 32'd30);
        wait_idle("fair");

        // Backpressure: consumer stalled, exactly 8 accepts
        res_ready = 1'b0;
        acc = 0;
`ifdef EXP_SCHED_PERF_CNT_EN
        pi0 = perf_issue_cnt;
        ps0 = perf_stall_cnt;
`endif
        for (int c = 0; c < 20; c++) begin
            step();
            set_x(64 + c);
            req_valid = '1;
            @(negedge clk);
            if (req_ready != '0) acc++;
            if (c == 8) chk("bp_inflt_max", 32'(in_flight), 32'd8);
        end
        chk("bp_accepts", 32'(acc), 32'd8);
        chk("bp_ready_blk", 32'(req_ready), 32'd0);
        chk("bp_inflt", 32'(in_flight), 32'd0);
        chk("bp_resv", 32'(res_valid), 32'd1);
        chk("bp_err", 32'(err_sticky), 32'd0);

        // One pop frees credit; the resulting return coincides with a second pop
        step();
        req_valid = 4'b0001;
        req_x[31:0] = 32'h1234_5678;
        res_ready = 1'b1;
`ifdef EXP_SCHED_PERF_CNT_EN
        chk("perf_issue", perf_issue_cnt - pi0, 32'd8);
        chk("perf_stall", perf_stall_cnt - ps0, 32'd12);
`endif
        @(negedge clk);
        chk("sim_blocked", 32'(req_ready), 32'd0);
        step();
        res_ready = 1'b0;
        @(negedge clk);
        chk("sim_resume", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        for (int k = 3; k <= 9; k++) begin
            step();
            if (k == 9) res_ready = 1'b1;
        end
        @(negedge clk);
        chk("sim_ret", 32'(exp_valid_i), 32'd1);
        chk("sim_resv", 32'(res_valid), 32'd1);
        wait_idle("sim");

        // Reset with 3 ops in flight; engine stub keeps running
        for (int c = 0; c < 3; c++) begin
            step();
            set_x(128 + c);
            req_valid = 4'b0001;
            @(negedge clk);
            chk("rf_ready", 32'(req_ready), 32'h1);
        end
        step();
        req_valid = '0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("rf_rst");
        sb_q.delete();
        step();
        rst = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            @(negedge clk);
            chk("rf_resv", 32'(res_valid), 32'd0);
        end
        chk("rf_err", 32'(err_sticky), 32'd1);
        chk("rf_inflt", 32'(in_flight), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
